// File: rtl/tile_fetch_arbiter.sv
// Two-requester round-robin arbiter in front of the tile pixel ROM.
// Each grant fetches column words 0 and 1 of one tile row and returns
// them packed as a 32-bit row with a one-cycle valid tagged to the requester.
module tile_fetch_arbiter (
  input  logic        clk_draw,
  input  logic        rst_draw,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [9:0]  req0_index,
  input  logic [2:0]  req0_row,
  input  logic [9:0]  req1_index,
  input  logic [2:0]  req1_row,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_data,
  output logic [9:0]  bram_index,
  output logic [2:0]  bram_row,
  output logic        bram_col,
  input  logic [15:0] bram_data
);

  typedef enum logic [1:0] {IDLE, COL0, COL1, DONE} state_t;

  state_t      state_q;
  logic        last_q;      // requester granted most recently
  logic        cur_id_q;    // requester that owns the in-flight fetch
  logic [15:0] col0_q;      // column 0 word waiting for its partner
  logic [1:0]  rsp_valid_q;
  logic [31:0] rsp_data_q;
  // The ROM address registers also serve as the latched request fields:
  // index and row are loaded at the handshake and stay put until the next one.
  logic [9:0]  bram_index_q;
  logic [2:0]  bram_row_q;
  logic        bram_col_q;
  logic [1:0]  grant_d;

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant_d = 2'b00;
    case (req_valid)
      2'b01:   grant_d = 2'b01;
      2'b10:   grant_d = 2'b10;
      2'b11:   grant_d = last_q ? 2'b01 : 2'b10;
      default: grant_d = 2'b00;
    endcase
  end

  // Accept only in IDLE, and never during reset so a reset cycle cannot handshake.
  always_comb begin
    req_ready = 2'b00;
    if ((state_q == IDLE) && !rst_draw) begin
      req_ready = grant_d;
    end
  end

  // Fetch sequencer: handshake -> col0 address -> col1 address -> pack and respond.
  always_ff @(posedge clk_draw) begin
    if (rst_draw) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      cur_id_q     <= 1'b0;
      col0_q       <= 16'h0000;
      rsp_valid_q  <= 2'b00;
      rsp_data_q   <= 32'h0000_0000;
      bram_index_q <= 10'h000;
      bram_row_q   <= 3'd0;
      bram_col_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (req_ready != 2'b00) begin
            cur_id_q     <= req_ready[1];
            last_q       <= req_ready[1];
            bram_index_q <= req_ready[1] ? req1_index : req0_index;
            bram_row_q   <= req_ready[1] ? req1_row : req0_row;
            bram_col_q   <= 1'b0;
            state_q      <= COL0;
          end
        end
        COL0: begin
          bram_col_q <= 1'b1;
          state_q    <= COL1;
        end
        COL1: begin
          col0_q  <= bram_data;
          state_q <= DONE;
        end
        DONE: begin
          rsp_data_q  <= {col0_q, bram_data};
          rsp_valid_q <= cur_id_q ? 2'b10 : 2'b01;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign bram_index = bram_index_q;
  assign bram_row   = bram_row_q;
  assign bram_col   = bram_col_q;

endmodule
